// File: rtl/app_div_pkg.sv
// app_div_pkg: shared types, widths and adder cell functions for the approximate divider/multiplier path
package app_div_pkg;
  localparam int DW_DEFAULT = 8;
  typedef enum logic [1:0] {IDLE, MAC, RADD, DONE} state_t;
  function automatic logic cell_sum(input logic approx, input logic a, input logic b, input logic c);
    return approx ? a : a ^ b ^ c;
  endfunction
  function automatic logic cell_cout(input logic approx, input logic a, input logic b, input logic c);
    return approx ? b : (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/app_add.sv
// app_add: W-bit ripple adder whose low APPROX_BITS cells are approximate; carry-out discarded
// Ports: a, b (W) addends; s (W) sum mod 2^W
module app_add
  import app_div_pkg::*;
#(
  parameter int W = 16,
  parameter int APPROX_BITS = 0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s
);
  logic [W-1:0] w_c;
  assign w_c[0] = 1'b0;
  for (genvar i = 0; i < W; i++) begin : g_cell
    assign s[i] = cell_sum(i < APPROX_BITS, a[i], b[i], w_c[i]);
    if (i > 0) begin : g_carry
      assign w_c[i] = cell_cout((i - 1) < APPROX_BITS, a[i-1], b[i-1], w_c[i-1]);
    end
  end
endmodule

// File: rtl/app_mul_reconstruct.sv
// app_mul_reconstruct: sequential MSB-first shift-add multiplier rebuilding p = q*y + r
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready with q, y, r (DW);
//        out_valid/out_ready with p (2*DW), zero whenever out_valid is low
module app_mul_reconstruct
  import app_div_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int APPROX_BITS = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] q,
  input  logic [DW-1:0] y,
  input  logic [DW-1:0] r,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2*DW-1:0] p
);
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_q, r_y, r_r;
  logic [2*DW-1:0] r_acc, w_a, w_b, w_sum;
  logic w_accept;
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign p         = out_valid ? r_acc : '0;
  assign w_accept  = in_valid & in_ready;
  // MAC shifts the accumulator and adds y for the current quotient bit; RADD folds in the remainder
  assign w_a = (r_state == RADD) ? r_acc : {r_acc[2*DW-2:0], 1'b0};
  assign w_b = (r_state == RADD) ? {{DW{1'b0}}, r_r} : (r_q[r_cnt] ? {{DW{1'b0}}, r_y} : '0);
  app_add #(.W(2*DW), .APPROX_BITS(APPROX_BITS)) u_add (.a(w_a), .b(w_b), .s(w_sum));
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_valid ? MAC : IDLE;
      MAC:     w_next = (r_cnt == '0) ? RADD : MAC;
      RADD:    w_next = DONE;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_q     <= '0;
      r_y     <= '0;
      r_r     <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_q   <= q;
        r_y   <= y;
        r_r   <= r;
        r_acc <= '0;
        r_cnt <= CW'(DW - 1);
      end else begin
        if (r_state == MAC || r_state == RADD) r_acc <= w_sum;
        if (r_state == MAC) r_cnt <= r_cnt - 1'b1;
      end
    end
  end
endmodule
